// File: rtl/axis_wave_source.sv
// AXI-Stream waveform source: phase-accumulator samples emitted as fixed-length frames.
// Optional stall counter output enabled by defining AXIS_WAVE_SOURCE_STALL_CNT_EN.
module axis_wave_source #(
    parameter int DATA_SIZE  = 32,
    parameter int ID_SIZE    = 4,
    parameter int PHASE_SIZE = 32,
    parameter int FRAME_LEN  = 256
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic [PHASE_SIZE-1:0] phase_inc,
    input  logic [1:0]            wave_sel,
    input  logic [ID_SIZE-1:0]    channel_id,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [DATA_SIZE-1:0]  m_tdata,
    output logic [ID_SIZE-1:0]    m_tid,
    output logic                  busy,
    output logic [15:0]           frame_count
`ifdef AXIS_WAVE_SOURCE_STALL_CNT_EN
    ,
    output logic [31:0]           stall_count
`endif
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_TRI    = 2'd1;
    localparam logic [1:0] WAVE_SQUARE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PHASE_SIZE-1:0] phase_q, phase_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [PHASE_SIZE-1:0] inc_q, inc_d;
    logic [1:0]            sel_q, sel_d;
    logic [ID_SIZE-1:0]    id_q, id_d;
    logic [15:0]           frames_q, frames_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_SIZE-1:0]  tdata_q, tdata_d;
    logic [ID_SIZE-1:0]    tid_q, tid_d;
    logic                  accept;
    logic                  load;

    function automatic logic [DATA_SIZE-1:0] wave_sample(
        input logic [PHASE_SIZE-1:0] ph,
        input logic [IDX_W-1:0]      idx,
        input logic [1:0]            sel
    );
        logic [DATA_SIZE-1:0] s;
        case (sel)
            WAVE_SAW:    s = ph[PHASE_SIZE-1 -: DATA_SIZE];
            WAVE_TRI:    s = {ph[PHASE_SIZE-1] ? ~ph[PHASE_SIZE-2 -: DATA_SIZE-1]
                                               :  ph[PHASE_SIZE-2 -: DATA_SIZE-1], 1'b0};
            WAVE_SQUARE: s = ph[PHASE_SIZE-1] ? '0 : '1;
            default:     s = DATA_SIZE'(idx);
        endcase
        return s;
    endfunction

    assign accept = tvalid_q & m_tready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        index_d  = index_q;
        inc_d    = inc_q;
        sel_d    = sel_q;
        id_d     = id_q;
        frames_d = frames_q;
        tvalid_d = tvalid_q;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                    index_d = '0;
                    inc_d   = phase_inc;
                    sel_d   = wave_sel;
                    id_d    = channel_id;
                    load    = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (accept) begin
                    // Phase advances by the step of the frame just accepted, before re-latching.
                    phase_d = phase_q + inc_q;
                    if (tlast_q) begin
                        index_d  = '0;
                        frames_d = frames_q + 16'd1;
                        inc_d    = phase_inc;
                        sel_d    = wave_sel;
                        id_d     = channel_id;
                        if ((state_q == ST_RUN) && enable) begin
                            load = 1'b1;
                        end else begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                        end
                    end else begin
                        index_d = index_q + 1'b1;
                        load    = 1'b1;
                        if (!enable) state_d = ST_DRAIN;
                    end
                end else if (!enable) begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tdata_d = tdata_q;
        tlast_d = tlast_q;
        tid_d   = tid_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = wave_sample(phase_d, index_d, sel_d);
            tlast_d  = (index_d == LAST_IDX);
            tid_d    = id_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            index_q  <= '0;
            inc_q    <= '0;
            sel_q    <= '0;
            id_q     <= '0;
            frames_q <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tid_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            index_q  <= index_d;
            inc_q    <= inc_d;
            sel_q    <= sel_d;
            id_q     <= id_d;
            frames_q <= frames_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tid_q    <= tid_d;
        end
    end

`ifdef AXIS_WAVE_SOURCE_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            stall_q <= '0;
        end else if (tvalid_q && !m_tready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`endif

    assign m_tvalid    = tvalid_q;
    assign m_tlast     = tlast_q;
    assign m_tdata     = tdata_q;
    assign m_tid       = tid_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_count = frames_q;

endmodule

// File: tb/tb_axis_wave_source.sv
// Bench for axis_wave_source: frame-level reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_axis_wave_source;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int PW = 16;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          areset;
    logic          enable;
    logic [PW-1:0] phase_inc;
    logic [1:0]    wave_sel;
    logic [IW-1:0] channel_id;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [DW-1:0] m_tdata;
    logic [IW-1:0] m_tid;
    logic          busy;
    logic [15:0]   frame_count;
`ifdef AXIS_WAVE_SOURCE_STALL_CNT_EN
    logic [31:0]   stall_count;
`endif

    axis_wave_source #(
        .DATA_SIZE (DW),
        .ID_SIZE   (IW),
        .PHASE_SIZE(PW),
        .FRAME_LEN (FL)
    ) dut (
        .aclk       (clk),
        .areset     (areset),
        .enable     (enable),
        .phase_inc  (phase_inc),
        .wave_sel   (wave_sel),
        .channel_id (channel_id),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tdata    (m_tdata),
        .m_tid      (m_tid),
        .busy       (busy),
        .frame_count(frame_count)
`ifdef AXIS_WAVE_SOURCE_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is FL beats; beat k of a frame has phase start + k*inc.
    bit          mdl_active = 1'b0;
    bit          mdl_stop   = 1'b0;
    int          mdl_idx    = 0;
    logic [15:0] mdl_ph     = '0;
    logic [15:0] mdl_inc    = '0;
    logic [1:0]  mdl_sel    = '0;
    logic [3:0]  mdl_id     = '0;
    logic [15:0] mdl_frames = '0;
    logic [31:0] mdl_stall  = '0;

    function automatic logic [15:0] exp_sample(input logic [15:0] ph, input int idx, input logic [1:0] sel);
        case (sel)
            2'd0:    return ph;
            2'd1:    return (ph < 16'h8000) ? 16'(2 * ph) : 16'(2 * (16'hFFFF - ph));
            2'd2:    return (ph < 16'h8000) ? 16'hFFFF : 16'h0000;
            default: return 16'(idx);
        endcase
    endfunction

    always @(posedge clk) begin
        if (areset) begin
            mdl_active = 1'b0;
            mdl_stop   = 1'b0;
            mdl_idx    = 0;
            mdl_ph     = '0;
            mdl_frames = '0;
            mdl_stall  = '0;
        end else if (!mdl_active) begin
            if (enable) begin
                mdl_active = 1'b1;
                mdl_stop   = 1'b0;
                mdl_idx    = 0;
                mdl_ph     = '0;
                mdl_inc    = phase_inc;
                mdl_sel    = wave_sel;
                mdl_id     = channel_id;
            end
        end else if (m_tready) begin
            mdl_ph = mdl_ph + mdl_inc;
            if (mdl_idx == FL - 1) begin
                mdl_frames = mdl_frames + 16'd1;
                mdl_idx    = 0;
                mdl_inc    = phase_inc;
                mdl_sel    = wave_sel;
                mdl_id     = channel_id;
                if (mdl_stop || !enable) begin
                    mdl_active = 1'b0;
                    mdl_stop   = 1'b0;
                end
            end else begin
                mdl_idx++;
                if (!enable) mdl_stop = 1'b1;
            end
        end else begin
            if (mdl_stall != 32'hFFFF_FFFF) mdl_stall = mdl_stall + 32'd1;
            if (!enable) mdl_stop = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tvalid", m_tvalid, mdl_active);
            check("busy", busy, mdl_active);
            check("frame_count", frame_count, mdl_frames);
`ifdef AXIS_WAVE_SOURCE_STALL_CNT_EN
            check("stall_count", stall_count, mdl_stall);
`endif
            if (mdl_active) begin
                check("tdata", m_tdata, exp_sample(mdl_ph, mdl_idx, mdl_sel));
                check("tlast", m_tlast, mdl_idx == FL - 1);
                check("tid", m_tid, mdl_id);
            end
        end
    end

    // Log of accepted beats as {tlast, tdata}, used to pin the model with literals.
    logic [31:0] log_q[$];

    always @(negedge clk) begin
        if (m_tvalid === 1'b1 && m_tready === 1'b1) log_q.push_back({15'b0, m_tlast, m_tdata});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_log(input string name, input int i, input logic [31:0] exp);
        if (i < log_q.size()) check(name, log_q[i], exp);
        else check(name, 32'hFFFF_FFFF, exp);
    endtask

    task automatic stop_and_wait();
        enable = 1'b0;
        for (int i = 0; i < 40 && busy; i++) step(1);
        check("drain_timeout", busy, 1'b0);
    endtask

    task automatic start(input logic [1:0] sel, input logic [15:0] inc, input logic [3:0] id);
        wave_sel   = sel;
        phase_inc  = inc;
        channel_id = id;
        enable     = 1'b1;
        step(1);
        log_q.delete();
    endtask

    initial begin
        areset     = 1'b1;
        enable     = 1'b0;
        m_tready   = 1'b1;
        phase_inc  = '0;
        wave_sel   = '0;
        channel_id = '0;
        step(2);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);
        check("rst_tdata", m_tdata, 16'd0);
        chk_en = 1'b1;
        areset = 1'b0;
        step(1);

        // Sample-index pattern; tvalid rises exactly one cycle after enable.
        wave_sel   = 2'd3;
        channel_id = 4'd5;
        phase_inc  = 16'h1234;
        enable     = 1'b1;
        check("s1_tvalid_before", m_tvalid, 1'b0);
        step(1);
        log_q.delete();
        check("s1_tvalid_after", m_tvalid, 1'b1);
        check("s1_tid", m_tid, 4'd5);
        step(4);
        check("s1_frame_count", frame_count, 16'd1);
        step(4);
        for (int i = 0; i < 8; i++)
            check_log("s1_beat", i, {15'b0, (i % 4) == 3, 16'(i % 4)});
        stop_and_wait();

        // Sawtooth: phase carries across the frame boundary.
        start(2'd0, 16'h1000, 4'd2);
        step(5);
        check_log("s2_b0", 0, 32'h0_0000);
        check_log("s2_b1", 1, 32'h0_1000);
        check_log("s2_b2", 2, 32'h0_2000);
        check_log("s2_b3", 3, 32'h1_3000);
        check_log("s2_b4", 4, 32'h0_4000);
        stop_and_wait();

        // Triangle.
        start(2'd1, 16'h4000, 4'd3);
        step(4);
        check_log("s3_b0", 0, 32'h0_0000);
        check_log("s3_b1", 1, 32'h0_8000);
        check_log("s3_b2", 2, 32'h0_FFFE);
        check_log("s3_b3", 3, 32'h1_7FFE);
        stop_and_wait();

        // Backpressure on beat 1 for three cycles.
        start(2'd0, 16'h1000, 4'd1);
        step(1);
        m_tready = 1'b0;
        step(3);
        check("s4_held_tvalid", m_tvalid, 1'b1);
        check("s4_held_tdata", m_tdata, 16'h1000);
`ifdef AXIS_WAVE_SOURCE_STALL_CNT_EN
        check("s4_stall_count", stall_count, 32'd3);
`endif
        m_tready = 1'b1;
        step(4);
        check_log("s4_b0", 0, 32'h0_0000);
        check_log("s4_b1", 1, 32'h0_1000);
        check_log("s4_b2", 2, 32'h0_2000);
        check_log("s4_b3", 3, 32'h1_3000);
        check_log("s4_b4", 4, 32'h0_4000);
        stop_and_wait();

        // Stop mid-frame: the frame completes, then the source idles.
        start(2'd0, 16'h1000, 4'd6);
        step(2);
        enable = 1'b0;
        step(2);
        check("s5_tvalid_idle", m_tvalid, 1'b0);
        check("s5_busy_idle", busy, 1'b0);
        check_log("s5_b2", 2, 32'h0_2000);
        check_log("s5_b3", 3, 32'h1_3000);
        enable = 1'b1;
        step(1);
        check("s5_restart_tvalid", m_tvalid, 1'b1);
        check("s5_restart_tdata", m_tdata, 16'h0000);

        // Mid-frame reset, then restart at phase 0.
        step(2);
        areset = 1'b1;
        step(1);
        check("s6_rst_tvalid", m_tvalid, 1'b0);
        check("s6_rst_busy", busy, 1'b0);
        check("s6_rst_frame_count", frame_count, 16'd0);
        areset = 1'b0;
        step(1);
        check("s6_restart_tvalid", m_tvalid, 1'b1);
        check("s6_restart_tdata", m_tdata, 16'h0000);

        // Randomized traffic: backpressure, enable toggles, mid-frame config churn, resets.
        for (int i = 0; i < 1500; i++) begin
            m_tready   = ($urandom_range(9) < 7);
            if ($urandom_range(19) == 0) enable = ~enable;
            phase_inc  = 16'($urandom);
            wave_sel   = 2'($urandom);
            channel_id = 4'($urandom);
            areset     = ($urandom_range(199) == 0);
            step(1);
        end
        areset   = 1'b0;
        m_tready = 1'b1;
        stop_and_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
